// File: rtl/bp_pred_pkg.sv
// Shared definitions for the perceptron branch-predictor front end.
//   state_t    : weight-read scheduler FSM states
//   MAX_B      : maximum branches per fetch group
//   ADDR_W     : weight-SRAM address width
//   WGT_W      : signed weight width (two's complement)
//   BTYPE_CODE : B-type instruction code shared with the branch-count stage
package bp_pred_pkg;

    localparam int MAX_B  = 4;
    localparam int ADDR_W = 8;
    localparam int WGT_W  = 8;

    localparam logic [2:0] BTYPE_CODE = 3'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bp_weight_read_sched.sv
// Weight-SRAM read scheduler for the perceptron branch predictor.
// Accepts one fetch group (branch count plus one weight address per branch),
// issues the reads one per cycle to a shared single-port SRAM through a
// request/grant port, collects the returned weights and presents them with
// per-branch taken bits to the prediction consumer.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid / o_ready     group handshake (o_ready only in IDLE)
//   i_consecutiveBNum_4   branch count, clamped to MAX_B
//   i_weightsAddr_32      weight addresses, slot k at [k*ADDR_W +: ADDR_W]
//   i_flush               front-end redirect, aborts the current group
//   o_ramReq_1/o_ramAddr_8/i_ramGrant_1/i_ramRdata_8  SRAM read port
//   o_predValid_1/i_predReady_1  result handshake
//   o_predNum_4, o_predTaken_4, o_weights_32          result payload
module bp_weight_read_sched #(
    parameter int MAX_B  = bp_pred_pkg::MAX_B,
    parameter int ADDR_W = bp_pred_pkg::ADDR_W,
    parameter int WGT_W  = bp_pred_pkg::WGT_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [3:0]              i_consecutiveBNum_4,
    input  logic [MAX_B*ADDR_W-1:0] i_weightsAddr_32,
    input  logic                    i_flush,
    output logic                    o_ramReq_1,
    output logic [ADDR_W-1:0]       o_ramAddr_8,
    input  logic                    i_ramGrant_1,
    input  logic [WGT_W-1:0]        i_ramRdata_8,
    output logic                    o_predValid_1,
    input  logic                    i_predReady_1,
    output logic [3:0]              o_predNum_4,
    output logic [MAX_B-1:0]        o_predTaken_4,
    output logic [MAX_B*WGT_W-1:0]  o_weights_32
);
    import bp_pred_pkg::*;

    localparam int CNT_W = $clog2(MAX_B + 1);
    localparam int IDX_W = $clog2(MAX_B);
    localparam logic signed [WGT_W-1:0] WGT_ZERO = '0;

    state_t state, state_nxt;

    logic [CNT_W-1:0]        num;
    logic [CNT_W-1:0]        num_in;
    logic [CNT_W-1:0]        issue_idx;
    logic [CNT_W-1:0]        recv_idx;
    logic [CNT_W-1:0]        recv_nxt;
    logic                    rd_pend;
    logic                    accept;
    logic                    granted;
    logic [ADDR_W-1:0]       addr [MAX_B];
    logic signed [WGT_W-1:0] wgt  [MAX_B];
    logic [MAX_B-1:0]        taken;
    logic [MAX_B*WGT_W-1:0]  wgt_flat;

    assign accept   = (state == IDLE) && i_valid && !i_flush;
    assign granted  = (state == ISSUE) && i_ramGrant_1;
    assign num_in   = (i_consecutiveBNum_4 > 4'(MAX_B)) ? CNT_W'(MAX_B)
                                                         : CNT_W'(i_consecutiveBNum_4);
    // Receive count including the word landing this cycle; lets WAIT leave
    // in the same cycle the last weight is captured.
    assign recv_nxt = recv_idx + CNT_W'(rd_pend);

    // Control state: FSM, issue/receive counters and the read-pending flag.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            state     <= IDLE;
            issue_idx <= '0;
            recv_idx  <= '0;
            rd_pend   <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_pend <= granted;
            if (accept) begin
                issue_idx <= '0;
                recv_idx  <= '0;
            end else begin
                if (granted) issue_idx <= issue_idx + CNT_W'(1);
                if (rd_pend) recv_idx  <= recv_nxt;
            end
        end
    end

    // Datapath: latched group and collected weights. Outputs are gated by
    // DONE, so these registers need no reset.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            num <= num_in;
            for (int k = 0; k < MAX_B; k++) begin
                addr[k] <= i_weightsAddr_32[k*ADDR_W +: ADDR_W];
                wgt[k]  <= WGT_ZERO;
            end
        end else if (rd_pend && !i_flush) begin
            wgt[recv_idx[IDX_W-1:0]] <= $signed(i_ramRdata_8);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = (num_in == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (i_ramGrant_1 && (issue_idx == num - CNT_W'(1))) state_nxt = WAIT;
            end
            WAIT: begin
                if (recv_nxt == num) state_nxt = DONE;
            end
            DONE: begin
                if (i_predReady_1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (i_flush) state_nxt = IDLE;
    end

    // A branch is predicted taken when its weight is non-negative; slots at
    // or beyond the latched count report not-taken.
    always_comb begin
        taken    = '0;
        wgt_flat = '0;
        for (int k = 0; k < MAX_B; k++) begin
            wgt_flat[k*WGT_W +: WGT_W] = wgt[k];
            taken[k] = (CNT_W'(k) < num) && (wgt[k] >= WGT_ZERO);
        end
    end

    always_comb begin
        o_ready       = (state == IDLE);
        o_ramReq_1    = (state == ISSUE);
        o_ramAddr_8   = (state == ISSUE) ? addr[issue_idx[IDX_W-1:0]] : '0;
        o_predValid_1 = (state == DONE);
        o_predNum_4   = (state == DONE) ? 4'(num) : 4'd0;
        o_predTaken_4 = (state == DONE) ? taken : '0;
        o_weights_32  = (state == DONE) ? wgt_flat : '0;
    end

endmodule

// File: tb/tb_bp_weight_read_sched.sv
// Self-checking bench for bp_weight_read_sched: SRAM model, group-level
// reference model and directed fetch-group scenarios.
module tb_bp_weight_read_sched;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_consecutiveBNum_4;
    logic [31:0] i_weightsAddr_32;
    logic        i_flush;
    logic        o_ramReq_1;
    logic [7:0]  o_ramAddr_8;
    logic        i_ramGrant_1;
    logic [7:0]  i_ramRdata_8;
    logic        o_predValid_1;
    logic        i_predReady_1;
    logic [3:0]  o_predNum_4;
    logic [3:0]  o_predTaken_4;
    logic [31:0] o_weights_32;

    bp_weight_read_sched dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_valid             (i_valid),
        .o_ready             (o_ready),
        .i_consecutiveBNum_4 (i_consecutiveBNum_4),
        .i_weightsAddr_32    (i_weightsAddr_32),
        .i_flush             (i_flush),
        .o_ramReq_1          (o_ramReq_1),
        .o_ramAddr_8         (o_ramAddr_8),
        .i_ramGrant_1        (i_ramGrant_1),
        .i_ramRdata_8        (i_ramRdata_8),
        .o_predValid_1       (o_predValid_1),
        .i_predReady_1       (i_predReady_1),
        .o_predNum_4         (o_predNum_4),
        .o_predTaken_4       (o_predTaken_4),
        .o_weights_32        (o_weights_32)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // SRAM contents and read-data return one cycle after a granted request.
    logic [7:0] mem [256];
    logic       rd_ok   = 1'b0;
    logic [7:0] rd_addr = 8'h00;
    assign i_ramRdata_8 = rd_ok ? mem[rd_addr] : 8'hEE;

    // Group-level reference model: which group is outstanding and how many
    // reads of it the arbiter has granted.
    logic       active = 1'b0;
    int         grants = 0;
    int         m_n    = 0;
    logic [7:0] m_addr [4];

    always @(posedge i_clk) begin
        rd_ok   <= o_ramReq_1 & i_ramGrant_1;
        rd_addr <= o_ramAddr_8;
        if (i_rst || i_flush) begin
            active <= 1'b0;
            grants <= 0;
        end else if (o_ready && i_valid) begin
            active <= 1'b1;
            grants <= 0;
            m_n    <= (i_consecutiveBNum_4 > 4'd4) ? 4 : int'(i_consecutiveBNum_4);
            for (int k = 0; k < 4; k++) m_addr[k] <= i_weightsAddr_32[k*8 +: 8];
        end else if (active) begin
            if (o_ramReq_1 && i_ramGrant_1) grants <= grants + 1;
            if (o_predValid_1 && i_predReady_1) active <= 1'b0;
        end
    end

    function automatic logic [31:0] model_w();
        logic [31:0] r = '0;
        for (int k = 0; k < 4; k++)
            if (k < m_n) r[k*8 +: 8] = mem[m_addr[k]];
        return r;
    endfunction

    function automatic logic [3:0] model_t();
        logic [3:0] r = '0;
        for (int k = 0; k < 4; k++)
            if (k < m_n) r[k] = ~mem[m_addr[k]][7];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of the DUT against the group-level model.
    task automatic compare();
        logic [7:0] ea;
        if (!i_rst) begin
            check("ready_vs_model", {31'd0, o_ready}, {31'd0, !active});
            if (o_ramReq_1) begin
                ea = (grants < 4) ? m_addr[grants] : 8'h00;
                check("req_in_group", {31'd0, active && (grants < m_n)}, 32'd1);
                check("req_addr", {24'd0, o_ramAddr_8}, {24'd0, ea});
            end
            if (o_predValid_1) begin
                check("pred_active", {31'd0, active}, 32'd1);
                check("pred_grants", grants, m_n);
                check("pred_num", {28'd0, o_predNum_4}, m_n);
                check("pred_w", o_weights_32, model_w());
                check("pred_taken", {28'd0, o_predTaken_4}, {28'd0, model_t()});
            end
        end
    endtask

    int         req_cnt  = 0;
    int         vld_cnt  = 0;
    int         hold_cnt = 0;
    logic [7:0] hold_addr = 8'hFF;

    task automatic tick();
        @(negedge i_clk);
        compare();
        if (o_ramReq_1) req_cnt++;
        if (o_predValid_1) vld_cnt++;
        if (o_ramReq_1 && o_ramAddr_8 == hold_addr) hold_cnt++;
    endtask

    // Present one group in an IDLE cycle T; return at the first cycle showing
    // o_predValid_1 with lat = cycles after T. Grant is withheld for the first
    // 'deny' cycles after acceptance.
    task automatic run_group(input logic [3:0] cnt, input logic [31:0] addrs,
                             input int deny, output int lat);
        i_valid             = 1'b1;
        i_consecutiveBNum_4 = cnt;
        i_weightsAddr_32    = addrs;
        i_ramGrant_1        = (deny == 0);
        tick();
        i_valid = 1'b0;
        lat = 1;
        while (!o_predValid_1 && lat < 40) begin
            i_ramGrant_1 = (lat > deny);
            tick();
            lat++;
        end
        i_ramGrant_1 = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
        check({tag, "_req"}, {31'd0, o_ramReq_1}, 32'd0);
        check({tag, "_addr"}, {24'd0, o_ramAddr_8}, 32'd0);
        check({tag, "_valid"}, {31'd0, o_predValid_1}, 32'd0);
        check({tag, "_num"}, {28'd0, o_predNum_4}, 32'd0);
        check({tag, "_taken"}, {28'd0, o_predTaken_4}, 32'd0);
        check({tag, "_w"}, o_weights_32, 32'd0);
    endtask

    initial begin
        int lat;
        int snap;
        logic [31:0] w_first;

        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[8'h10] = 8'h05;
        mem[8'h20] = 8'hF0;
        mem[8'h30] = 8'h7F;
        mem[8'h40] = 8'h80;

        i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
        i_ramGrant_1 = 1'b1; i_predReady_1 = 1'b1;
        i_consecutiveBNum_4 = 4'd0; i_weightsAddr_32 = 32'd0;
        repeat (3) tick();
        i_rst = 1'b0;
        tick();
        check_reset_outputs("reset");

        // n=4, full grant: valid at T+6.
        run_group(4'd4, 32'h40302010, 0, lat);
        check("n4_latency", lat, 6);
        check("n4_weights", o_weights_32, 32'h807FF005);
        check("n4_taken", {28'd0, o_predTaken_4}, 32'h5);
        check("n4_num", {28'd0, o_predNum_4}, 32'd4);
        tick();
        check("n4_back_idle", {31'd0, o_ready}, 32'd1);

        // n=0: valid at T+1, no SRAM traffic.
        snap = req_cnt;
        run_group(4'd0, 32'h11223344, 0, lat);
        check("n0_latency", lat, 1);
        check("n0_weights", o_weights_32, 32'd0);
        check("n0_taken", {28'd0, o_predTaken_4}, 32'd0);
        check("n0_no_req", req_cnt, snap);
        tick();

        // n=2 with three lost grants: address held four cycles, valid at T+7.
        hold_addr = 8'h10;
        hold_cnt  = 0;
        run_group(4'd2, 32'hAABB2010, 3, lat);
        check("deny_latency", lat, 7);
        check("deny_hold", hold_cnt, 4);
        check("deny_weights", o_weights_32, 32'h0000F005);
        check("deny_taken", {28'd0, o_predTaken_4}, 32'h1);
        check("deny_num", {28'd0, o_predNum_4}, 32'd2);
        hold_addr = 8'hFF;
        tick();

        // Flush during ISSUE after the first grant, then an n=1 group.
        snap = vld_cnt;
        i_valid = 1'b1; i_consecutiveBNum_4 = 4'd3; i_weightsAddr_32 = 32'h00104030;
        i_ramGrant_1 = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("flush_idle", {31'd0, o_ready}, 32'd1);
        check("flush_no_valid", vld_cnt, snap);
        run_group(4'd1, 32'h00000020, 0, lat);
        check("after_flush_latency", lat, 3);
        check("after_flush_weights", o_weights_32, 32'h000000F0);
        check("after_flush_taken", {28'd0, o_predTaken_4}, 32'd0);
        tick();

        // Consumer stalls five cycles in DONE.
        i_predReady_1 = 1'b0;
        run_group(4'd2, 32'h00003040, 0, lat);
        check("stall_latency", lat, 4);
        check("stall_weights", o_weights_32, 32'h00007F80);
        check("stall_taken", {28'd0, o_predTaken_4}, 32'h2);
        w_first = o_weights_32;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_valid_held", {31'd0, o_predValid_1}, 32'd1);
            check("stall_not_ready", {31'd0, o_ready}, 32'd0);
            check("stall_w_stable", o_weights_32, w_first);
        end
        i_predReady_1 = 1'b1;
        tick();
        check("release_ready", {31'd0, o_ready}, 32'd1);
        check("release_valid", {31'd0, o_predValid_1}, 32'd0);

        // Count above four clamps to four.
        run_group(4'd9, 32'h40302010, 0, lat);
        check("clamp_latency", lat, 6);
        check("clamp_num", {28'd0, o_predNum_4}, 32'd4);
        check("clamp_weights", o_weights_32, 32'h807FF005);
        tick();

        // Reset in the middle of ISSUE.
        i_valid = 1'b1; i_consecutiveBNum_4 = 4'd4; i_weightsAddr_32 = 32'h40302010;
        tick();
        i_valid = 1'b0;
        tick();
        i_rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        i_rst = 1'b0;
        tick();
        run_group(4'd1, 32'h00000030, 0, lat);
        check("post_rst_latency", lat, 3);
        check("post_rst_weights", o_weights_32, 32'h0000007F);
        check("post_rst_taken", {28'd0, o_predTaken_4}, 32'h1);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_weight_read_sched.md
# bp_weight_read_sched

Sequences weight-SRAM reads for the perceptron branch predictor in the instruction-fetch front end. It accepts one fetch group's consecutive-B count (0–4) and four 8-bit weight addresses from the branch-count/address stage. It issues those reads one per cycle to a shared single-port weight SRAM through a request/grant port. It then presents the collected weights and per-branch taken bits to the prediction consumer through a valid/ready handshake.

## Interface
Parameters:
- MAX_B, 4, maximum branches per fetch group.
- ADDR_W, 8, weight-SRAM address width.
- WGT_W, 8, signed weight width (two's complement).

Ports:
- i_clk  in  1  single clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  fetch-group count and addresses are valid.
- o_ready  out  1  scheduler can accept a group (high only in IDLE).
- i_consecutiveBNum_4  in  4  consecutive-B count; values >4 clamp to 4.
- i_weightsAddr_32  in  32  four addresses; slot k at bits [8k+:8].
- i_flush  in  1  front-end redirect; abort the current group.
- o_ramReq_1  out  1  SRAM read request.
- o_ramAddr_8  out  8  SRAM read address.
- i_ramGrant_1  in  1  arbiter grant for the current request (update path may win).
- i_ramRdata_8  in  8  read data, valid exactly 1 cycle after a granted request.
- o_predValid_1  out  1  prediction result valid.
- i_predReady_1  in  1  consumer accepts the result.
- o_predNum_4  out  4  latched clamped count n.
- o_predTaken_4  out  4  bit k = taken for branch k.
- o_weights_32  out  32  collected weights; slot k at bits [8k+:8].

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, DONE.
- **IDLE:**
  - o_ready=1.
  - On i_valid & ~i_flush: latch n=min(count,4) and all four addresses; clear weights to 0; issue index=0.
  - Next state: DONE if n==0, else ISSUE.
- **ISSUE:**
  - o_ramReq_1=1; o_ramAddr_8=addr[issue index].
  - On grant: issue index++, and set rdPend for the next cycle.
  - After the grant for index n-1, go to WAIT. Without a grant, hold request and address stable.
- **Data capture:** any cycle rdPend=1 writes i_ramRdata_8 into weight[recv index], then recv index++. This works in ISSUE (pipelined) and in WAIT.
- **WAIT:** no request. Go to DONE once recv index==n.
- **DONE:**
  - o_predValid_1=1; outputs stable.
  - Taken bit k = ~weight[k][7] for k<n, 0 for k≥n. Weight slots k≥n stay 0.
  - On i_predReady_1, go to IDLE.
- **Flush:**
  - i_flush in any state forces IDLE next cycle; o_predValid_1 drops and counters clear.
  - rdPend clears, so data returning the cycle after flush is discarded.
  - Flush beats i_valid in the same cycle: no accept.
- **Reset:** takes effect in any state, mid-read included; state and counters are identical to flush.

## Timing
- **Reset values:** o_ready=1 after reset release; o_ramReq_1=0, o_ramAddr_8=0, o_predValid_1=0, o_predNum_4=0, o_predTaken_4=0, o_weights_32=0.
- **Latency:** accept in cycle T with a grant every cycle gives o_predValid_1 in T+n+2 (n≥1). For n=0, valid in T+1.
- Each lost grant adds one cycle.
- **Throughput:** one group per n+3 cycles at best (no IDLE/DONE overlap).
- **SRAM port:** at most one outstanding read. Address changes only in the cycle after a grant.
- **Consumer handshake:** o_predValid_1 held until i_predReady_1. The consumer may hold ready high permanently.

## Structure
- **Package bp_pred_pkg:**
  - state enum (IDLE/ISSUE/WAIT/DONE)
  - MAX_B=4, ADDR_W=8, WGT_W=8
  - the B-type code (3'd1) shared with the branch-count stage.
- **Modules:** a single module; no sub-module is warranted.

## Test plan
- n=4, addresses 0x10/0x20/0x30/0x40, grant always, SRAM returns 0x05/0xF0/0x7F/0x80 -> valid at T+6, weights 0x807FF005, taken=4'b0101, predNum=4.
- n=0 -> valid at T+1, weights 0, taken 0, no ramReq.
- n=2, grant low for 3 cycles before the first grant -> address 0x10 held for 4 cycles, valid at T+7, slots 2–3 zero.
- i_flush during ISSUE after first grant (n=3) -> IDLE next cycle, no predValid, returning data dropped; the next group (n=1) yields only its own weight.
- predReady low for 5 cycles in DONE -> outputs stable, o_ready=0 throughout; ready high -> IDLE, o_ready=1 next cycle.
- count=4'd9 -> clamps to n=4; i_rst asserted mid-ISSUE -> all outputs at reset values next cycle.
